// File: rtl/cla16_registered.sv
// 16-bit two-level carry-lookahead adder with registered sum, carry vector and group P/G.
// Four 4-bit lookahead blocks feed a second-level unit that produces the block carry-ins.
module cla16_registered (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        C0,
   output logic [15:0] C,
   output logic [15:0] S,
   output logic        P,
   output logic        G
);

   logic [15:0] p;
   logic [15:0] g;
   logic [3:0]  pb;
   logic [3:0]  gb;
   logic [4:0]  cb;
   logic [16:0] c;
   logic        p_grp;
   logic        g_grp;

   assign p = A ^ B;
   assign g = A & B;

   always_comb begin
      pb = '0;
      gb = '0;
      for (int k = 0; k < 4; k++) begin
         pb[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         gb[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
   end

   // Second level: group terms exclude C0 so the block composes into wider adders.
   assign p_grp = &pb;
   assign g_grp = gb[3]
                | (pb[3] & gb[2])
                | (pb[3] & pb[2] & gb[1])
                | (pb[3] & pb[2] & pb[1] & gb[0]);

   assign cb[0] = C0;
   assign cb[1] = gb[0] | (pb[0] & C0);
   assign cb[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & C0);
   assign cb[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                | (pb[2] & pb[1] & pb[0] & C0);
   assign cb[4] = g_grp | (p_grp & C0);

   always_comb begin
      c = '0;
      for (int k = 0; k < 4; k++) begin
         c[4*k]   = cb[k];
         c[4*k+1] = g[4*k] | (p[4*k] & cb[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cb[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & cb[k]);
      end
      c[16] = cb[4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S <= '0;
         C <= '0;
         P <= 1'b0;
         G <= 1'b0;
      end else begin
         S <= p ^ c[15:0];
         C <= c[16:1];
         P <= p_grp;
         G <= g_grp;
      end
   end

endmodule

// File: tb/tb_cla16_registered.sv
// Bench for cla16_registered: directed corner cases plus random vectors against an
// arithmetic reference model, including an asynchronous reset mid-run.
module tb_cla16_registered;

   logic        clk;
   logic        rst_n;
   logic [15:0] A;
   logic [15:0] B;
   logic        C0;
   logic [15:0] C;
   logic [15:0] S;
   logic        P;
   logic        G;

   int n_assert;
   int n_fail;

   cla16_registered dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .C0    (C0),
      .C     (C),
      .S     (S),
      .P     (P),
      .G     (G)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Carry out of bit i is bit (i+1) of the sum of the low (i+1) bits of each operand.
   function automatic logic [15:0] ref_carry(input logic [15:0] a, input logic [15:0] b,
                                             input logic c0);
      logic [15:0] r;
      int unsigned mask;
      int unsigned s;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         mask = (32'd1 << (i + 1)) - 32'd1;
         s = (int'(a) & mask) + (int'(b) & mask) + int'(c0);
         r[i] = s[i+1];
      end
      return r;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_S"}, {16'h0, S}, 32'h0);
      check({tag, "_C"}, {16'h0, C}, 32'h0);
      check({tag, "_P"}, {31'h0, P}, 32'h0);
      check({tag, "_G"}, {31'h0, G}, 32'h0);
   endtask

   // Apply one vector, clock it in, then compare against the reference model.
   task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c0);
      int unsigned sum;
      logic exp_g;
      logic exp_p;
      A = a;
      B = b;
      C0 = c0;
      @(posedge clk);
      #1;
      sum = int'(a) + int'(b) + int'(c0);
      exp_g = ((int'(a) + int'(b)) >> 16) != 0;
      exp_p = ((a ^ b) == 16'hFFFF);
      check({tag, "_S"}, {16'h0, S}, sum & 32'hFFFF);
      check({tag, "_C"}, {16'h0, C}, {16'h0, ref_carry(a, b, c0)});
      check({tag, "_P"}, {31'h0, P}, {31'h0, exp_p});
      check({tag, "_G"}, {31'h0, G}, {31'h0, exp_g});
      check({tag, "_ident"}, {31'h0, C[15]}, {31'h0, G | (P & c0)});
   endtask

   logic [15:0] d_a   [6] = '{16'h0008, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0FFF, 16'h7FFF};
   logic [15:0] d_b   [6] = '{16'h0004, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h8000};
   logic        d_c0  [6] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
   logic [15:0] d_s   [6] = '{16'h000C, 16'hFFFE, 16'h0000, 16'h0100, 16'h1000, 16'h0000};
   logic [15:0] d_c   [6] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0FFF, 16'hFFFF};
   logic        d_p   [6] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1};
   logic        d_g   [6] = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0};

   initial begin
      n_assert = 0;
      n_fail = 0;
      rst_n = 1'b0;
      A = 16'hA5A5;
      B = 16'h5A5A;
      C0 = 1'b1;
      #3;
      check_zero("rst_noclk");
      @(posedge clk);
      #1;
      check_zero("rst_held");
      @(negedge clk);
      A = 16'h0;
      B = 16'h0;
      C0 = 1'b0;
      rst_n = 1'b1;
      run_vec("post_rst", 16'h0, 16'h0, 1'b0);
      check_zero("post_rst_zero");

      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("dir%0d", i), d_a[i], d_b[i], d_c0[i]);
         check($sformatf("dir%0d_Sk", i), {16'h0, S}, {16'h0, d_s[i]});
         check($sformatf("dir%0d_Ck", i), {16'h0, C}, {16'h0, d_c[i]});
         check($sformatf("dir%0d_Pk", i), {31'h0, P}, {31'h0, d_p[i]});
         check($sformatf("dir%0d_Gk", i), {31'h0, G}, {31'h0, d_g[i]});
      end

      for (int i = 0; i < 10000; i++) begin
         run_vec("rnd", 16'($urandom), 16'($urandom), 1'($urandom));
         if (i == 5000) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_zero("rst_mid");
            #1;
            rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
